// File: rtl/data_packer_if.sv
// Stream bundle around the data packer: narrow input words plus FLUSH in,
// packed wide words with a lane count out, both on valid/ready handshakes.
interface data_packer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int NUM_WORDS = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * NUM_WORDS;
  localparam int CNT_WIDTH = $clog2(NUM_WORDS + 1);

  // Handshake: a word moves on a cycle where both valid and ready are high at
  // the rising edge; valid never waits on ready, and ready may depend on valid.
  logic                 DIN_VALID;
  logic [IN_WIDTH-1:0]  DIN;
  logic                 DIN_READY;
  logic                 FLUSH;
  logic                 DOUT_VALID;
  logic [OUT_WIDTH-1:0] DOUT;
  logic [CNT_WIDTH-1:0] DOUT_COUNT;
  logic                 DOUT_READY;

  modport master (
    output DIN_VALID, DIN, FLUSH, DOUT_READY,
    input  DIN_READY, DOUT_VALID, DOUT, DOUT_COUNT
  );

  modport slave (
    input  DIN_VALID, DIN, FLUSH, DOUT_READY,
    output DIN_READY, DOUT_VALID, DOUT, DOUT_COUNT
  );
endinterface

// File: rtl/data_packer.sv
// Packs NUM_WORDS narrow words (lane 0 first) into one wide word; FLUSH emits
// a partial word, deferred through flush_pend while the output is occupied.
module data_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  data_packer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH * NUM_WORDS;
  localparam int CNT_WIDTH = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(NUM_WORDS);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] n_lanes;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] dout_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 valid_q;
  logic                 flush_pend;
  logic                 out_free;
  logic                 din_ready;
  logic                 accept;
  logic                 complete;
  logic                 flush_req;
  logic                 do_flush;

  always_comb begin
    out_free  = !valid_q || bus.DOUT_READY;
    din_ready = !RESET && !flush_pend && ((cnt != LAST) || out_free);
    accept    = bus.DIN_VALID && din_ready;
    complete  = accept && (cnt == LAST);
    n_lanes   = cnt + {{(CNT_WIDTH-1){1'b0}}, accept};
    // A word completed this cycle already carries every lane, so FLUSH adds nothing.
    flush_req = flush_pend || (bus.FLUSH && (n_lanes != '0) && !complete);
    do_flush  = flush_req && out_free;
    acc_next  = acc;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (accept && (cnt == CNT_WIDTH'(k))) begin
        acc_next[k*IN_WIDTH +: IN_WIDTH] = bus.DIN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      acc        <= '0;
      dout_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      flush_pend <= 1'b0;
    end else if (complete || do_flush) begin
      // Unfilled lanes of acc are already zero, so partial words need no masking.
      dout_q     <= acc_next;
      count_q    <= complete ? FULL : n_lanes;
      valid_q    <= 1'b1;
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (bus.DOUT_READY) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
      end
      if (flush_req) begin
        flush_pend <= 1'b1;
      end
    end
  end

  assign bus.DIN_READY  = din_ready;
  assign bus.DOUT_VALID = valid_q;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_COUNT = count_q;
endmodule

// File: tb/tb_data_packer.sv
// Bench for data_packer: scenario tasks drive the input stream, a negedge
// monitor pops expected {count, word} entries from exp_q on every emit.
module tb_data_packer;
  localparam int IW = 16;
  localparam int NW = 4;
  localparam int OW = IW * NW;
  localparam int CW = $clog2(NW + 1);
  localparam int W  = OW + CW;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_packer_if #(.IN_WIDTH(IW), .NUM_WORDS(NW)) bus ();
  data_packer #(.IN_WIDTH(IW), .NUM_WORDS(NW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard monitor: sampled mid-cycle, consistent with the coming rising edge.
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  always @(negedge CLK) begin
    if (!RESET && bus.DOUT_VALID && bus.DOUT_READY) begin
      mon_got = {bus.DOUT_COUNT, bus.DOUT};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dout_unexpected: got count=%0d dout=%h, required no output",
                 bus.DOUT_COUNT, bus.DOUT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL dout_word: got count=%0d dout=%h, required count=%0d dout=%h",
                   mon_got[W-1:OW], mon_got[OW-1:0], mon_exp[W-1:OW], mon_exp[OW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.DIN_VALID = 1'b0;
    bus.FLUSH     = 1'b0;
  endtask

  task automatic push_exp(input logic [OW-1:0] word, input int count);
    exp_q.push_back({CW'(count), word});
  endtask

  // Offers one word and waits (bounded) for it to be taken.
  task automatic send(input logic [IW-1:0] w);
    int t = 0;
    bus.DIN_VALID = 1'b1;
    bus.DIN       = w;
    #1;
    while (!bus.DIN_READY && t < 40) begin
      step();
      t++;
    end
    if (t >= 40) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got DIN_READY=0 for 40 cycles, required 1 (din=%h)", w);
    end
    step();
    bus.DIN_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    bus.DOUT_READY = 1'b1;
    while (exp_q.size() != 0 && t < 30) begin
      step();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.DIN_VALID  = 1'b1;
    bus.DIN        = 16'h1234;
    bus.FLUSH      = 1'b0;
    bus.DOUT_READY = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.DIN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_din_ready: got %b, required 0", bus.DIN_READY);
    end
    n_cmp++;
    if (bus.DOUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dout_valid: got %b, required 0", bus.DOUT_VALID);
    end
    n_cmp++;
    if (bus.DOUT !== '0) begin
      n_fail++;
      $display("FAIL reset_dout: got %h, required 0", bus.DOUT);
    end
    n_cmp++;
    if (bus.DOUT_COUNT !== '0) begin
      n_fail++;
      $display("FAIL reset_dout_count: got %0d, required 0", bus.DOUT_COUNT);
    end
    RESET = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (bus.DIN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_din_ready: got %b, required 1", bus.DIN_READY);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.DOUT_READY = 1'b1;
    push_exp(64'h0004_0003_0002_0001, 4);
    push_exp(64'h0008_0007_0006_0005, 4);
    for (int i = 1; i <= 8; i++) begin
      bus.DIN_VALID = 1'b1;
      bus.DIN       = IW'(i);
      #1;
      n_cmp++;
      if (bus.DIN_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_din_ready: got %b, required 1 (din=%0d)", bus.DIN_READY, i);
      end
      if (i == 4 || i == 5) begin
        n_cmp++;
        if (bus.DOUT_VALID !== (i == 5)) begin
          n_fail++;
          $display("FAIL b2b_latency: got DOUT_VALID=%b at din=%0d, required %b",
                   bus.DOUT_VALID, i, (i == 5));
        end
      end
      step();
    end
    idle();
    drain("b2b");
  endtask

  task automatic test_backpressure();
    bus.DOUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) send(IW'(16'h11 + i));
    push_exp(64'h0014_0013_0012_0011, 4);
    for (int i = 0; i < 3; i++) begin
      bus.DIN_VALID = 1'b1;
      bus.DIN       = IW'(16'h21 + i);
      #1;
      n_cmp++;
      if (bus.DIN_READY !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_accept: got DIN_READY=%b for lane %0d, required 1", bus.DIN_READY, i);
      end
      step();
    end
    bus.DIN = 16'h24;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.DIN_READY !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall: got DIN_READY=%b, required 0", bus.DIN_READY);
      end
      n_cmp++;
      if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 64'h0014_0013_0012_0011 ||
          bus.DOUT_COUNT !== CW'(4)) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b dout=%h count=%0d, required 1 0014001300120011 4",
                 bus.DOUT_VALID, bus.DOUT, bus.DOUT_COUNT);
      end
      step();
    end
    push_exp(64'h0024_0023_0022_0021, 4);
    bus.DOUT_READY = 1'b1;
    #1;
    n_cmp++;
    if (bus.DIN_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got DIN_READY=%b, required 1", bus.DIN_READY);
    end
    step();
    idle();
    n_cmp++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 64'h0024_0023_0022_0021) begin
      n_fail++;
      $display("FAIL bp_next_word: got valid=%b dout=%h, required 1 0024002300220021",
               bus.DOUT_VALID, bus.DOUT);
    end
    drain("bp");
  endtask

  task automatic test_partial_flush();
    bus.DOUT_READY = 1'b1;
    send(16'h000A);
    send(16'h000B);
    push_exp(64'h0000_0000_000B_000A, 2);
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    push_exp(64'h0004_0003_0002_0001, 4);
    for (int i = 1; i <= 4; i++) send(IW'(i));
    drain("partial_flush");
  endtask

  task automatic test_flush_concurrent();
    bus.DOUT_READY = 1'b1;
    send(16'h000A);
    send(16'h000B);
    push_exp(64'h0000_000C_000B_000A, 3);
    bus.DIN_VALID = 1'b1;
    bus.DIN       = 16'h000C;
    bus.FLUSH     = 1'b1;
    step();
    idle();
    drain("flush_din");
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.DOUT_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_flush: got DOUT_VALID=%b, required 0", bus.DOUT_VALID);
      end
      step();
    end
    for (int i = 1; i <= 3; i++) send(IW'(i));
    push_exp(64'h0004_0003_0002_0001, 4);
    bus.DIN_VALID = 1'b1;
    bus.DIN       = 16'h0004;
    bus.FLUSH     = 1'b1;
    step();
    idle();
    drain("full_flush");
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.DOUT_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL full_flush_extra: got DOUT_VALID=%b, required 0", bus.DOUT_VALID);
      end
      step();
    end
  endtask

  task automatic test_pending_flush();
    bus.DOUT_READY = 1'b0;
    for (int i = 1; i <= 4; i++) send(IW'(i));
    push_exp(64'h0004_0003_0002_0001, 4);
    send(16'h0055);
    push_exp(64'h0000_0000_0000_0055, 1);
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    bus.DIN_VALID = 1'b1;
    bus.DIN       = 16'h0066;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.DIN_READY !== 1'b0) begin
        n_fail++;
        $display("FAIL pend_din_ready: got %b, required 0", bus.DIN_READY);
      end
      step();
    end
    bus.DIN_VALID  = 1'b0;
    bus.DOUT_READY = 1'b1;
    step();
    n_cmp++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT_COUNT !== CW'(1)) begin
      n_fail++;
      $display("FAIL pend_partial: got valid=%b count=%0d, required 1 1",
               bus.DOUT_VALID, bus.DOUT_COUNT);
    end
    drain("pend");
  endtask

  task automatic test_reset_mid_word();
    bus.DOUT_READY = 1'b1;
    send(16'h0071);
    send(16'h0072);
    send(16'h0073);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    n_cmp++;
    if (bus.DOUT_VALID !== 1'b0 || bus.DOUT_COUNT !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b count=%0d, required 0 0",
               bus.DOUT_VALID, bus.DOUT_COUNT);
    end
    push_exp(64'h0004_0003_0002_0001, 4);
    for (int i = 1; i <= 4; i++) send(IW'(i));
    drain("mid_reset");
  endtask

  task automatic push_lanes(ref logic [IW-1:0] lanes[$]);
    logic [OW-1:0] w = '0;
    for (int k = 0; k < lanes.size(); k++) w[k*IW +: IW] = lanes[k];
    push_exp(w, lanes.size());
    lanes.delete();
  endtask

  task automatic test_random();
    logic [IW-1:0] lanes[$];
    logic [IW-1:0] d;
    logic v;
    logic fl;
    for (int i = 0; i < 400; i++) begin
      bus.DOUT_READY = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      d  = IW'($urandom_range(0, 16'hFFFF));
      fl = bus.DOUT_READY && ($urandom_range(0, 7) == 0);
      bus.DIN_VALID = v;
      bus.DIN       = d;
      bus.FLUSH     = fl;
      #1;
      if (v && bus.DIN_READY) lanes.push_back(d);
      if (lanes.size() == NW) push_lanes(lanes);
      else if (fl && lanes.size() > 0) push_lanes(lanes);
      step();
    end
    idle();
    if (lanes.size() > 0) begin
      bus.DOUT_READY = 1'b1;
      bus.FLUSH      = 1'b1;
      push_lanes(lanes);
      step();
      bus.FLUSH = 1'b0;
    end
    drain("random");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    RESET          = 1'b1;
    bus.DIN_VALID  = 1'b0;
    bus.DIN        = '0;
    bus.FLUSH      = 1'b0;
    bus.DOUT_READY = 1'b0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_partial_flush();
    test_flush_concurrent();
    test_pending_flush();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
